// File: rtl/histo_ram_sched_if.sv
// Bus between the histogram RAM scheduler and its surroundings (ADC stream, RAM port A, UART tx FSM).
// The sat_flag member exists only when HISTO_SATURATE_EN is defined.
interface histo_ram_sched_if #(
  parameter int WIDTH_DATA  = 16,
  parameter int LENGTH_ADDR = 10,
  parameter int NSAMP_WIDTH = 32
);
  logic                   start;
  logic [NSAMP_WIDTH-1:0] n_samples;
  logic                   adc_valid;
  logic [LENGTH_ADDR-1:0] adc_code;
  logic                   adc_ready;
  logic                   ram_wen;
  logic [LENGTH_ADDR-1:0] ram_addr_a;
  logic [WIDTH_DATA-1:0]  ram_din_a;
  logic [WIDTH_DATA-1:0]  ram_dout_a;
  logic                   tx_run;
  logic                   tx_done;
  logic                   busy;
  logic [1:0]             phase;
  logic                   done;
`ifdef HISTO_SATURATE_EN
  logic                   sat_flag;
`endif

  modport master (
    input  start, n_samples, adc_valid, adc_code, ram_dout_a, tx_done,
    output adc_ready, ram_wen, ram_addr_a, ram_din_a, tx_run, busy, phase, done
`ifdef HISTO_SATURATE_EN
    , output sat_flag
`endif
  );

  modport slave (
    output start, n_samples, adc_valid, adc_code, ram_dout_a, tx_done,
    input  adc_ready, ram_wen, ram_addr_a, ram_din_a, tx_run, busy, phase, done
`ifdef HISTO_SATURATE_EN
    , input sat_flag
`endif
  );
endinterface

// File: rtl/histo_ram_sched.sv
// Owner of the shared histogram RAM: ACQUIRE (read-modify-write bins), DUMP (UART reads port B), CLEAR.
// Define HISTO_SATURATE_EN to make bins saturate at all-ones and expose the sticky sat_flag.
module histo_ram_sched #(
  parameter int WIDTH_DATA  = 16,
  parameter int LENGTH_ADDR = 10,
  parameter int NSAMP_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  histo_ram_sched_if.master bus
);
  localparam logic [LENGTH_ADDR-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ_RD,
    S_ACQ_WR,
    S_DUMP,
    S_CLEAR
  } state_e;

  state_e                 state_q, state_d;
  logic [NSAMP_WIDTH-1:0] n_samp_q, cnt_q, cnt_inc;
  logic [LENGTH_ADDR-1:0] code_q, clr_addr_q;
  logic [1:0]             phase_q;
  logic                   busy_q, done_q;
  logic [WIDTH_DATA-1:0]  bin_next;
  logic                   start_ok;

  function automatic logic [1:0] phase_of(state_e s);
    case (s)
      S_ACQ_RD, S_ACQ_WR: phase_of = 2'b01;
      S_DUMP:             phase_of = 2'b10;
      S_CLEAR:            phase_of = 2'b11;
      default:            phase_of = 2'b00;
    endcase
  endfunction

  assign start_ok = (state_q == S_IDLE) && bus.start;
  assign cnt_inc  = cnt_q + NSAMP_WIDTH'(1);

`ifdef HISTO_SATURATE_EN
  assign bin_next = (&bus.ram_dout_a) ? bus.ram_dout_a : bus.ram_dout_a + WIDTH_DATA'(1);
`else
  assign bin_next = bus.ram_dout_a + WIDTH_DATA'(1);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = (bus.n_samples == '0) ? S_DUMP : S_ACQ_RD;
      S_ACQ_RD: if (bus.adc_valid) state_d = S_ACQ_WR;
      S_ACQ_WR: state_d = (cnt_inc == n_samp_q) ? S_DUMP : S_ACQ_RD;
      S_DUMP:   if (bus.tx_done) state_d = S_CLEAR;
      S_CLEAR:  if (clr_addr_q == LAST_ADDR) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.adc_ready  = 1'b0;
    bus.ram_wen    = 1'b0;
    bus.ram_addr_a = '0;
    bus.ram_din_a  = '0;
    bus.tx_run     = 1'b0;
    case (state_q)
      S_ACQ_RD: begin
        bus.adc_ready = 1'b1;
        if (bus.adc_valid) bus.ram_addr_a = bus.adc_code;
      end
      S_ACQ_WR: begin
        // The read issued last cycle returns now; the write lands before the next read.
        bus.ram_wen    = 1'b1;
        bus.ram_addr_a = code_q;
        bus.ram_din_a  = bin_next;
      end
      S_DUMP:  bus.tx_run = 1'b1;
      S_CLEAR: begin
        bus.ram_wen    = 1'b1;
        bus.ram_addr_a = clr_addr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_samp_q   <= '0;
      cnt_q      <= '0;
      code_q     <= '0;
      clr_addr_q <= '0;
      phase_q    <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // phase/busy are registered from the next state so they line up with state_q.
      phase_q <= phase_of(state_d);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_q == S_CLEAR) && (clr_addr_q == LAST_ADDR);
      if (start_ok) begin
        n_samp_q <= bus.n_samples;
        cnt_q    <= '0;
      end
      if (state_q == S_ACQ_RD && bus.adc_valid) code_q <= bus.adc_code;
      if (state_q == S_ACQ_WR) cnt_q <= cnt_inc;
      if (state_q == S_CLEAR) clr_addr_q <= clr_addr_q + LENGTH_ADDR'(1);
      else                    clr_addr_q <= '0;
    end
  end

  assign bus.phase = phase_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

`ifdef HISTO_SATURATE_EN
  logic sat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                            sat_q <= 1'b0;
    else if (start_ok)                                   sat_q <= 1'b0;
    else if (state_q == S_ACQ_WR && (&bus.ram_dout_a))   sat_q <= 1'b1;
  end

  assign bus.sat_flag = sat_q;
`endif
endmodule

// File: tb/tb_histo_ram_sched.sv
// Self-checking bench for histo_ram_sched: a phase-level model predicts every output each cycle,
// and a bench-side RAM holds the histogram so bin contents can be checked against hand values.
module tb_histo_ram_sched;
  localparam int WD    = 16;
  localparam int LA    = 10;
  localparam int NW    = 32;
  localparam int DEPTH = 1 << LA;

  logic clk = 1'b0;
  logic rst = 1'b0;

  histo_ram_sched_if #(.WIDTH_DATA(WD), .LENGTH_ADDR(LA), .NSAMP_WIDTH(NW)) bus ();

  histo_ram_sched #(.WIDTH_DATA(WD), .LENGTH_ADDR(LA), .NSAMP_WIDTH(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench RAM: port A, synchronous read-first with one cycle latency, plus bench-only fill/preload.
  logic [WD-1:0] mem [DEPTH];
  logic          fill_en = 1'b0, fill_pat = 1'b0, pre_en = 1'b0;
  logic [LA-1:0] pre_addr = '0;
  logic [WD-1:0] pre_val = '0;

  // NOTE: the RAM array has no reset; its contents survive rst just like the real block RAM.
  always @(posedge clk) begin
    if (fill_en) for (int i = 0; i < DEPTH; i++) mem[i] <= fill_pat ? WD'(i) : '0;
    if (pre_en) mem[pre_addr] <= pre_val;
    if (bus.ram_wen) mem[bus.ram_addr_a] <= bus.ram_din_a;
    bus.ram_dout_a <= mem[bus.ram_addr_a];
  end

  // Phase-level model: phase 0 idle, 1 acquire, 2 dump, 3 clear; m_pend marks a fetched sample awaiting its write.
  logic [WD-1:0] exp_hist [DEPTH];
  int            m_phase, m_clr;
  bit            m_pend, m_done, m_sat;
  logic [LA-1:0] m_code;
  logic [NW-1:0] m_left;

  always @(posedge clk or negedge rst) begin
    if (fill_en) for (int i = 0; i < DEPTH; i++) exp_hist[i] = fill_pat ? WD'(i) : '0;
    if (pre_en) exp_hist[pre_addr] = pre_val;
    if (!rst) begin
      m_phase = 0; m_pend = 0; m_left = '0; m_clr = 0; m_done = 0; m_sat = 0; m_code = '0;
    end else begin
      m_done = 0;
      case (m_phase)
        0: if (bus.start) begin
          m_left  = bus.n_samples;
          m_sat   = 0;
          m_pend  = 0;
          m_phase = (bus.n_samples == 0) ? 2 : 1;
        end
        1: if (m_pend) begin
`ifdef HISTO_SATURATE_EN
          if (exp_hist[m_code] == {WD{1'b1}}) m_sat = 1;
          else exp_hist[m_code] = exp_hist[m_code] + WD'(1);
`else
          exp_hist[m_code] = WD'((int'(exp_hist[m_code]) + 1) % (1 << WD));
`endif
          m_pend = 0;
          m_left = m_left - 1;
          if (m_left == 0) m_phase = 2;
        end else if (bus.adc_valid) begin
          m_pend = 1;
          m_code = bus.adc_code;
        end
        2: if (bus.tx_done) begin m_phase = 3; m_clr = 0; end
        3: begin
          exp_hist[m_clr] = '0;
          if (m_clr == DEPTH - 1) begin m_phase = 0; m_done = 1; end
          else m_clr++;
        end
        default: m_phase = 0;
      endcase
    end
  end

  function automatic logic [WD-1:0] bumped(input logic [WD-1:0] v);
`ifdef HISTO_SATURATE_EN
    return (v == {WD{1'b1}}) ? v : v + WD'(1);
`else
    return WD'((int'(v) + 1) % (1 << WD));
`endif
  endfunction

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_hist[i]) n++;
    return n;
  endfunction

  // Compare process plus DUT-activity counters used by the directed checks.
  int acq_cyc, clr_cyc, done_cnt, wen_cnt;

  always @(negedge clk) begin
    check("busy", bus.busy, m_phase != 0);
    check("phase", bus.phase, m_phase);
    check("adc_ready", bus.adc_ready, m_phase == 1 && !m_pend);
    check("ram_wen", bus.ram_wen, (m_phase == 1 && m_pend) || m_phase == 3);
    check("tx_run", bus.tx_run, m_phase == 2);
    check("done", bus.done, m_done);
    if (m_phase == 3) begin
      check("clr_addr", bus.ram_addr_a, m_clr);
      check("clr_din", bus.ram_din_a, 0);
    end else if (m_phase == 1 && m_pend) begin
      check("wr_addr", bus.ram_addr_a, m_code);
      check("wr_din", bus.ram_din_a, bumped(exp_hist[m_code]));
    end else if (m_phase == 1 && bus.adc_valid) begin
      check("rd_addr", bus.ram_addr_a, bus.adc_code);
    end
`ifdef HISTO_SATURATE_EN
    check("sat_flag", bus.sat_flag, m_sat);
`endif
    if (bus.phase == 2'b01) acq_cyc++;
    if (bus.phase == 2'b11) clr_cyc++;
    if (bus.done) done_cnt++;
    if (bus.ram_wen) wen_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [NW-1:0] n);
    bus.n_samples = n;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_tx_done();
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  task automatic send(input logic [LA-1:0] code);
    int k = 0;
    bus.adc_code  = code;
    bus.adc_valid = 1'b1;
    while (!bus.adc_ready && k < 50) begin @(negedge clk); k++; end
    check("send_accepted", bus.adc_ready, 1);
    @(negedge clk);
    bus.adc_valid = 1'b0;
  endtask

  task automatic wait_phase(input logic [1:0] p, input int budget);
    int k = 0;
    while (bus.phase != p && k < budget) begin @(negedge clk); k++; end
    check("wait_phase", bus.phase, p);
  endtask

  task automatic finish_run();
    wait_phase(2'b10, 100);
    pulse_tx_done();
    wait_phase(2'b00, DEPTH + 50);
    step(1);
  endtask

  task automatic clear_counters();
    acq_cyc = 0; clr_cyc = 0; done_cnt = 0; wen_cnt = 0;
  endtask

  initial begin
    int k;
    bus.start = 1'b0; bus.n_samples = '0; bus.adc_valid = 1'b0; bus.adc_code = '0; bus.tx_done = 1'b0;
    fill_en = 1'b1; fill_pat = 1'b0;
    step(2);
    fill_en = 1'b0;
    check("rst_phase", bus.phase, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_wen", bus.ram_wen, 0);
    rst = 1'b1;
    step(2);

    // Codes 5,5,5,9: eight acquire cycles, then DUMP holding tx_run until tx_done.
    clear_counters();
    pulse_start(4);
    send(5); send(5); send(5); send(9);
    wait_phase(2'b10, 20);
    check("acq_cycles", acq_cyc, 8);
    check("bin5", mem[5], 3);
    check("bin9", mem[9], 1);
    check("bin6", mem[6], 0);
    check("hist_after_acq", mem_diff(), 0);
    step(5);
    check("tx_run_held", bus.tx_run, 1);
    pulse_tx_done();
    check("tx_run_dropped", bus.tx_run, 0);
    wait_phase(2'b00, DEPTH + 50);
    step(1);
    check("done_pulses", done_cnt, 1);
    check("clear_cycles", clr_cyc, DEPTH);
    check("bin5_cleared", mem[5], 0);
    check("hist_after_clear", mem_diff(), 0);

    // n_samples = 0: straight to DUMP, only the clear writes port A.
    clear_counters();
    pulse_start(0);
    check("zero_to_dump", bus.phase, 2);
    step(3);
    check("zero_no_acq_writes", wen_cnt, 0);
    pulse_tx_done();
    wait_phase(2'b00, DEPTH + 50);
    step(1);
    check("zero_done_pulses", done_cnt, 1);
    check("zero_clear_cycles", clr_cyc, DEPTH);
    check("zero_writes", wen_cnt, DEPTH);

    // adc_valid idle for 10 cycles, then boundary codes 0 and 1023.
    clear_counters();
    pulse_start(2);
    step(10);
    check("idle_phase", bus.phase, 1);
    check("idle_ready", bus.adc_ready, 1);
    check("idle_no_writes", wen_cnt, 0);
    send(0); send(10'd1023);
    wait_phase(2'b10, 20);
    check("bin0", mem[0], 1);
    check("bin1023", mem[1023], 1);
    finish_run();

    // Full bin hit twice.
    pre_addr = 10'd3; pre_val = 16'hFFFF; pre_en = 1'b1;
    step(1);
    pre_en = 1'b0;
    pulse_start(2);
    send(3); send(3);
    wait_phase(2'b10, 20);
`ifdef HISTO_SATURATE_EN
    check("bin3_saturated", mem[3], 16'hFFFF);
    check("sat_flag_set", bus.sat_flag, 1);
`else
    check("bin3_wrapped", mem[3], 16'h0001);
`endif
    finish_run();

    // start pulses during DUMP and CLEAR are ignored.
    clear_counters();
    pulse_start(1);
    send(8);
    wait_phase(2'b10, 20);
    pulse_start(5);
    check("start_in_dump", bus.phase, 2);
    pulse_tx_done();
    step(100);
    pulse_start(7);
    check("start_in_clear", bus.phase, 3);
    wait_phase(2'b00, DEPTH + 50);
    step(2);
    check("single_done", done_cnt, 1);
    check("stays_idle", bus.phase, 0);

    // Reset in the middle of CLEAR at address 500.
    fill_pat = 1'b1; fill_en = 1'b1;
    step(1);
    fill_en = 1'b0;
    pulse_start(0);
    pulse_tx_done();
    k = 0;
    while (!(bus.phase == 2'b11 && bus.ram_addr_a == 10'd500) && k < 2 * DEPTH) begin @(negedge clk); k++; end
    check("reached_500", bus.ram_addr_a, 500);
    #2 rst = 1'b0;
    #1;
    check("midrst_phase", bus.phase, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_wen", bus.ram_wen, 0);
    check("midrst_addr", bus.ram_addr_a, 0);
    check("midrst_tx_run", bus.tx_run, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1);
    check("bin499_cleared", mem[499], 0);
    check("bin500_kept", mem[500], 500);
    check("bin1023_kept", mem[1023], 1023);
    check("hist_after_midrst", mem_diff(), 0);
    pulse_start(1);
    send(2);
    wait_phase(2'b10, 20);
    check("rerun_bin2", mem[2], 1);
    check("rerun_bin600", mem[600], 600);
    finish_run();
    check("rerun_bin600_cleared", mem[600], 0);
    check("hist_final", mem_diff(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/histo_ram_sched.md
Name: histo_ram_sched

Overview:
- Scheduler for the shared dual-port histogram RAM in the ADC code-density chain.
- Sequences three phases:
  - ACQUIRE: read-modify-write bin increments on RAM port A from the ADC code stream.
  - DUMP: hands the RAM to the UART transmitter FSM, which reads port B.
  - CLEAR: zeroes every bin through port A.
- Sits between the ADC sample path, the RAM and the UART tx FSM; only one phase owns the RAM at a time.

Parameters:
- WIDTH_DATA, 16, bin width in bits (RAM word width).
- LENGTH_ADDR, 10, address width; DEPTH = 2**LENGTH_ADDR bins.
- NSAMP_WIDTH, 32, width of the sample-count register.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a run when idle.
- n_samples  input  NSAMP_WIDTH  samples to accumulate; latched on the accepted start.
- adc_valid  input  1  ADC code valid.
- adc_code  input  LENGTH_ADDR  ADC code, used as bin address.
- adc_ready  output  1  sample accepted when adc_valid && adc_ready.
- ram_wen  output  1  port A write enable.
- ram_addr_a  output  LENGTH_ADDR  port A address.
- ram_din_a  output  WIDTH_DATA  port A write data.
- ram_dout_a  input  WIDTH_DATA  port A read data, registered, 1-cycle latency.
- tx_run  output  1  level; high enables the UART tx FSM during DUMP.
- tx_done  input  1  one-cycle pulse from the UART FSM after the last word is sent.
- busy  output  1  high in any state except IDLE.
- phase  output  2  00 idle, 01 acquire, 10 dump, 11 clear.
- done  output  1  one-cycle pulse when CLEAR completes.

Behaviour:
- Reset (rst low, async) forces state IDLE and clears all counters. All outputs go to 0.
- RAM contents are not affected by reset; a full run ends in CLEAR, leaving the RAM zeroed.
- States: IDLE, ACQ_RD, ACQ_WR, DUMP, CLEAR.
- IDLE:
  - On start, latch n_samples and clear the sample counter.
  - If n_samples == 0, go to DUMP; otherwise go to ACQ_RD.
  - start is ignored in every other state.
- ACQ_RD:
  - adc_ready = 1.
  - On handshake, drive ram_addr_a = adc_code with ram_wen = 0, register the code, go to ACQ_WR.
- ACQ_WR:
  - adc_ready = 0.
  - ram_addr_a = registered code, ram_wen = 1, ram_din_a = ram_dout_a + 1.
  - Increment the sample counter. If count reaches n_samples go to DUMP, else go to ACQ_RD.
  - Throughput is one sample per 2 clk.
  - No forwarding is needed: the write lands before the next read is issued, so back-to-back identical codes accumulate correctly.
- Arithmetic: bin increment is modulo 2**WIDTH_DATA (see optional feature). The sample counter is NSAMP_WIDTH bits and compared for equality.
- DUMP:
  - tx_run = 1, ram_wen = 0, adc_ready = 0.
  - Wait for tx_done, then drop tx_run on the next cycle and go to CLEAR.
  - A tx_done pulse outside DUMP is ignored.
- CLEAR:
  - ram_wen = 1, ram_din_a = 0, address counter runs 0 to DEPTH-1, one word per clk.
  - After address DEPTH-1 is written, pulse done for 1 cycle and go to IDLE.
  - Total duration is exactly DEPTH cycles.
- adc_valid while not in ACQ_RD: the sample is neither accepted nor counted. The source holds or drops it.
- phase and busy are registered and track the state in the same cycle.

Optional Feature:
- Macro HISTO_SATURATE_EN.
- Defined: ACQ_WR writes min(ram_dout_a + 1, 2**WIDTH_DATA-1), so a full bin stays at 16'hFFFF and the count still increments. A sticky output port sat_flag (1 bit) sets on the first saturation event and clears on the next accepted start or on reset.
- Undefined: bins wrap 16'hFFFF -> 0, and the sat_flag port is absent.

Test Plan:
- Reset released, start with n_samples=4, codes 5,5,5,9 -> ACQ lasts 8 clk, then DUMP. RAM[5]=3, RAM[9]=1, all other bins 0. tx_run high until tx_done.
- Start with n_samples=0 -> IDLE goes straight to DUMP with no port-A writes. After tx_done, CLEAR runs 1024 cycles, then a single done pulse; all bins are 0.
- adc_valid held low for 10 clk in ACQ_RD -> no counting, state stays ACQ_RD, adc_ready stays 1. Later handshakes complete the run normally.
- Preload RAM[3]=16'hFFFF, n_samples=2, codes 3,3 -> with HISTO_SATURATE_EN, RAM[3]=16'hFFFF and sat_flag=1. Without it, RAM[3]=16'h0001.
- rst driven low mid-CLEAR at address 500 -> outputs 0 immediately, state IDLE. Bins 500-1023 keep their old values. A second start runs cleanly.
- start pulsed during DUMP and again during CLEAR -> both ignored; a single done pulse ends the run.
